aib_link_bringup_ctrl: RTL and testbench
========================================

# aib_link_bringup_ctrl

Sequencer for a single AIB Gen2 leader PHY and the AXI-MM bridge behind it. Holds the AIB adapter in reset, issues a parameterised list of Avalon-MM configuration writes, then releases `i_conf_done` and `ns_mac_rdy`. Waits until channel 0 reports transfer-enable and alignment, then asserts `link_up`, which gates the bridge's `tx_online`/`rx_online`. Timeouts and link loss trigger bounded automatic retries.

## Interface
- NUM_CFG, 4: number of configuration writes in `cfg_table` (1..16).
- RST_HOLD_CYC, 16: cycles `ns_adapter_rstn` is held low per attempt (≥2).
- TIMEOUT_CYC, 65535: cycles allowed in WAIT_LINK before an attempt fails (<2^20).
- MAX_RETRY, 3: failed attempts tolerated before ERROR (1..15).

Ports:
- avmm_clk  in  1  sole clock.
- avmm_rst_n  in  1  asynchronous active-low reset.
- start  in  1  level enable; 1 = bring the link up and keep it up.
- cfg_table  in  NUM_CFG*64  entry i = bits [64i+63:64i]; upper 32 bits = address, lower 32 bits = write data; quasi-static.
- o_cfg_avmm_addr  out  32  AVMM address.
- o_cfg_avmm_byte_en  out  4  constant 4'hF while writing, else 0.
- o_cfg_avmm_write  out  1  AVMM write strobe.
- o_cfg_avmm_wdata  out  32  AVMM write data.
- i_cfg_avmm_waitreq  in  1  AVMM waitrequest.
- ns_adapter_rstn  out  1  adapter reset to PHY, active low.
- i_conf_done  out  1  configuration-complete to PHY.
- ns_mac_rdy  out  1  MAC-ready to PHY.
- ms_tx_transfer_en, ms_rx_transfer_en, sl_tx_transfer_en, sl_rx_transfer_en  in  1 each  channel-0 status from PHY; asynchronous.
- m_rx_align_done  in  1  channel-0 alignment status; asynchronous.
- link_up  out  1  all five status inputs high, and in state UP.
- link_err  out  1  sticky fail indication (state ERROR).
- retry_cnt  out  4  failed attempts since leaving IDLE.
- state_o  out  3  current state encoding.

## Operation
- The five status inputs pass through 2-flop synchronisers, which reset to 0. `status_ok` is the AND of the synchronised values.
- State encodings: IDLE=0, RST=1, CFG=2, CONF=3, WAIT_LINK=4, UP=5, ERROR=6.
- **IDLE**
  - All outputs are 0, including `ns_adapter_rstn=0`.
  - `start=1` → RST. `retry_cnt` clears to 0 on entering RST from IDLE.
- **RST**
  - Holds `ns_adapter_rstn=0`, `i_conf_done=0`, `ns_mac_rdy=0` for RST_HOLD_CYC cycles.
  - Then → CFG with index=0 and `ns_adapter_rstn=1` from that cycle on.
- **CFG**
  - Drives `write=1`, `byte_en=4'hF`, and addr/wdata from entry[index].
  - A write is accepted on a cycle with `write & !waitreq`.
  - On acceptance: index+1 and the next entry is presented the following cycle (back-to-back allowed).
  - After entry NUM_CFG-1 is accepted: `write` drops next cycle → CONF.
- **CONF**
  - One cycle. `i_conf_done` and `ns_mac_rdy` go to 1 and stay 1 until the attempt ends.
  - → WAIT_LINK with the timeout counter cleared.
- **WAIT_LINK**
  - `status_ok` → UP.
  - Counter reaching TIMEOUT_CYC-1 without `status_ok` = failed attempt.
- **UP**
  - `link_up=1`.
  - `status_ok` falling = failed attempt (link lost).
- **Failed attempt**
  - `retry_cnt`+1 (saturating at 15).
  - New count < MAX_RETRY → RST, which deasserts `ns_adapter_rstn`, `i_conf_done` and `ns_mac_rdy`.
  - Otherwise → ERROR.
- **ERROR**
  - `link_err=1`, `ns_adapter_rstn=0`, `i_conf_done=0`, `ns_mac_rdy=0`.
  - Leaves only when `start=0` → IDLE.
- **start=0**
  - In any state except CFG: → IDLE next cycle.
  - In CFG with `write=1 & waitreq=1`: the pending write stays asserted and unchanged until accepted, then → IDLE. AVMM protocol is never violated.
  - Takes priority over a simultaneous timeout or link loss; `retry_cnt` is not incremented.

## Timing
- Reset values:
  - `state_o=0`.
  - All AVMM outputs 0.
  - `ns_adapter_rstn=0`, `i_conf_done=0`, `ns_mac_rdy=0`.
  - `link_up=0`, `link_err=0`, `retry_cnt=0`.
  - Synchronisers 0, index 0, counters 0.
- All outputs are registered; no combinational path from input to output.
- `start` rises in cycle 0 → state RST in cycle 1.
- With `waitreq=0`:
  - `ns_adapter_rstn` rises at cycle 1+RST_HOLD_CYC, together with the first `write`.
  - The last write is at cycle RST_HOLD_CYC+NUM_CFG.
  - `i_conf_done` rises at RST_HOLD_CYC+NUM_CFG+1.
- Status input to `link_up`: 2 synchroniser cycles + 1 state cycle = 3 cycles.
- Status drop to `link_up=0`: 3 cycles; `ns_adapter_rstn=0` in the same cycle.
- Asynchronous reset mid-write: `write` drops immediately (asynchronous clear).

## Test plan
- **Nominal bring-up.** NUM_CFG=4, RST_HOLD_CYC=16, waitreq=0, status raised 20 cycles after `i_conf_done`. Required: 4 writes on consecutive cycles with exact addr/wdata; `i_conf_done` at cycle 21; `link_up` 3 cycles after status; `retry_cnt=0`.
- **Waitrequest stall.** Hold waitreq=1 for 5 cycles on entry 2. Required: addr/wdata unchanged through the stall; entry 3 follows the cycle after acceptance; exactly 4 accepted writes.
- **Timeout retry, then success.** TIMEOUT_CYC=100, status held low. Required: after 100 cycles in WAIT_LINK, `ns_adapter_rstn` drops and `retry_cnt=1`; the full write sequence repeats; raising status on the second attempt gives `link_up`.
- **Retry exhaustion.** MAX_RETRY=3, status never rises. Required: `retry_cnt=3`, `link_err=1`, `state_o=6`. Dropping `start` gives IDLE; raising it again gives `retry_cnt=0`.
- **Link loss in UP.** Drop `sl_rx_transfer_en` for 1 cycle. Required: `link_up=0` 3 cycles later, `retry_cnt=1`, re-bring-up completes.
- **Abort during stall.** Deassert `start` during a waitreq stall in CFG; separately, deassert `start` in the same cycle as a timeout. Required: the write is held until accepted, then IDLE; no increment of `retry_cnt`.

Source files
------------

// File: rtl/aib_link_bringup_ctrl.sv
// aib_link_bringup_ctrl: bring-up sequencer for one AIB Gen2 leader PHY.
// Holds the adapter in reset, streams the configuration table over AVMM,
// signals configuration done / MAC ready, then waits for channel 0 to
// report transfer-enable plus alignment before declaring the link up.
// Timeouts and link loss restart the sequence up to MAX_RETRY times.
module aib_link_bringup_ctrl #(
  parameter int NUM_CFG      = 4,      // 1..16 table entries
  parameter int RST_HOLD_CYC = 16,     // >= 2
  parameter int TIMEOUT_CYC  = 65535,  // < 2^20
  parameter int MAX_RETRY    = 3       // 1..15
) (
  input  logic                  avmm_clk,
  input  logic                  avmm_rst_n,
  input  logic                  start,
  input  logic [NUM_CFG*64-1:0] cfg_table,
  output logic [31:0]           o_cfg_avmm_addr,
  output logic [3:0]            o_cfg_avmm_byte_en,
  output logic                  o_cfg_avmm_write,
  output logic [31:0]           o_cfg_avmm_wdata,
  input  logic                  i_cfg_avmm_waitreq,
  output logic                  ns_adapter_rstn,
  output logic                  i_conf_done,
  output logic                  ns_mac_rdy,
  input  logic                  ms_tx_transfer_en,
  input  logic                  ms_rx_transfer_en,
  input  logic                  sl_tx_transfer_en,
  input  logic                  sl_rx_transfer_en,
  input  logic                  m_rx_align_done,
  output logic                  link_up,
  output logic                  link_err,
  output logic [3:0]            retry_cnt,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_CFG   = 3'd2,
    S_CONF  = 3'd3,
    S_WAIT  = 3'd4,
    S_UP    = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam int IDX_W   = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int CNT_MAX = (RST_HOLD_CYC > TIMEOUT_CYC) ? RST_HOLD_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_t             state;
  logic [IDX_W-1:0]   cfg_idx;
  logic [IDX_W-1:0]   cfg_idx_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         status_meta;
  logic [4:0]         status_sync;
  logic               status_ok;
  logic [3:0]         retry_nxt;
  logic               abort;
  logic               fail;
  logic [63:0]        cfg_entry [NUM_CFG];

  // Unpack the flat table into addressable {addr, wdata} entries.
  for (genvar g = 0; g < NUM_CFG; g++) begin : g_entry
    assign cfg_entry[g] = cfg_table[64*g +: 64];
  end

  // Two-flop synchronisers for the asynchronous PHY status bits.
  // NOTE: non-blocking assignments make meta->sync a true two-stage shift;
  // blocking ones would collapse both stages into a single flop.
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      status_meta <= '0;
      status_sync <= '0;
    end else begin
      status_meta <= {ms_tx_transfer_en, ms_rx_transfer_en, sl_tx_transfer_en,
                      sl_rx_transfer_en, m_rx_align_done};
      status_sync <= status_meta;
    end
  end

  assign status_ok   = &status_sync;
  assign cfg_idx_nxt = cfg_idx + IDX_W'(1);
  assign retry_nxt   = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;

  // A pending AVMM write is never withdrawn: start=0 only aborts once the
  // current write is accepted (or immediately, outside CFG).
  assign abort = !start && !(state == S_CFG && i_cfg_avmm_waitreq);
  assign fail  = !status_ok &&
                 ((state == S_WAIT && cnt == CNT_W'(TIMEOUT_CYC - 1)) || state == S_UP);

  assign state_o = state;

  // Bring-up FSM; every output is a register updated alongside the state.
  // NOTE: the asynchronous reset clears the AVMM strobe immediately, so a
  // write in flight is dropped without waiting for a clock edge.
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      state              <= S_IDLE;
      cfg_idx            <= '0;
      cnt                <= '0;
      o_cfg_avmm_addr    <= '0;
      o_cfg_avmm_wdata   <= '0;
      o_cfg_avmm_byte_en <= '0;
      o_cfg_avmm_write   <= 1'b0;
      ns_adapter_rstn    <= 1'b0;
      i_conf_done        <= 1'b0;
      ns_mac_rdy         <= 1'b0;
      link_up            <= 1'b0;
      link_err           <= 1'b0;
      retry_cnt          <= '0;
    end else if (abort) begin
      // start dropped: everything returns to the idle (all-zero) state
      state              <= S_IDLE;
      cfg_idx            <= '0;
      cnt                <= '0;
      o_cfg_avmm_addr    <= '0;
      o_cfg_avmm_wdata   <= '0;
      o_cfg_avmm_byte_en <= '0;
      o_cfg_avmm_write   <= 1'b0;
      ns_adapter_rstn    <= 1'b0;
      i_conf_done        <= 1'b0;
      ns_mac_rdy         <= 1'b0;
      link_up            <= 1'b0;
      link_err           <= 1'b0;
      retry_cnt          <= '0;
    end else if (fail) begin
      // timeout or link loss: restart the attempt or give up
      retry_cnt       <= retry_nxt;
      cnt             <= '0;
      ns_adapter_rstn <= 1'b0;
      i_conf_done     <= 1'b0;
      ns_mac_rdy      <= 1'b0;
      link_up         <= 1'b0;
      if (retry_nxt < 4'(MAX_RETRY)) begin
        state <= S_RST;
      end else begin
        state    <= S_ERROR;
        link_err <= 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RST;
            cnt       <= '0;
            retry_cnt <= '0;
          end
        end
        S_RST: begin
          if (cnt == CNT_W'(RST_HOLD_CYC - 1)) begin
            state              <= S_CFG;
            cfg_idx            <= '0;
            ns_adapter_rstn    <= 1'b1;
            o_cfg_avmm_write   <= 1'b1;
            o_cfg_avmm_byte_en <= 4'hF;
            o_cfg_avmm_addr    <= cfg_entry[0][63:32];
            o_cfg_avmm_wdata   <= cfg_entry[0][31:0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CFG: begin
          if (!i_cfg_avmm_waitreq) begin
            if (cfg_idx == IDX_W'(NUM_CFG - 1)) begin
              state              <= S_CONF;
              o_cfg_avmm_write   <= 1'b0;
              o_cfg_avmm_byte_en <= '0;
              o_cfg_avmm_addr    <= '0;
              o_cfg_avmm_wdata   <= '0;
              i_conf_done        <= 1'b1;
              ns_mac_rdy         <= 1'b1;
            end else begin
              cfg_idx          <= cfg_idx_nxt;
              o_cfg_avmm_addr  <= cfg_entry[cfg_idx_nxt][63:32];
              o_cfg_avmm_wdata <= cfg_entry[cfg_idx_nxt][31:0];
            end
          end
        end
        S_CONF: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (status_ok) begin
            state   <= S_UP;
            link_up <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;  // UP and ERROR only leave via fail/abort above
      endcase
    end
  end

endmodule

// File: tb/tb_aib_link_bringup_ctrl.sv
// tb_aib_link_bringup_ctrl: randomized self-checking bench. Expected
// behaviour comes from a cycle-budget model of the bring-up sequence
// (reset hold, per-entry write acceptance, status latency, timeout window).
module tb_aib_link_bringup_ctrl;

  localparam int NUM_CFG      = 4;
  localparam int RST_HOLD_CYC = 16;
  localparam int TIMEOUT_CYC  = 100;
  localparam int MAX_RETRY    = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RST   = 3'd1;
  localparam logic [2:0] ST_CFG   = 3'd2;
  localparam logic [2:0] ST_CONF  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_UP    = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  logic                  avmm_clk = 1'b0;
  logic                  avmm_rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [NUM_CFG*64-1:0] cfg_table = '0;
  logic [31:0]           o_cfg_avmm_addr;
  logic [3:0]            o_cfg_avmm_byte_en;
  logic                  o_cfg_avmm_write;
  logic [31:0]           o_cfg_avmm_wdata;
  logic                  i_cfg_avmm_waitreq = 1'b0;
  logic                  ns_adapter_rstn;
  logic                  i_conf_done;
  logic                  ns_mac_rdy;
  logic                  ms_tx_transfer_en = 1'b0;
  logic                  ms_rx_transfer_en = 1'b0;
  logic                  sl_tx_transfer_en = 1'b0;
  logic                  sl_rx_transfer_en = 1'b0;
  logic                  m_rx_align_done = 1'b0;
  logic                  link_up;
  logic                  link_err;
  logic [3:0]            retry_cnt;
  logic [2:0]            state_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] tbl [NUM_CFG];   // model copy of the configuration table
  logic [63:0] acc_q [$];       // writes observed being accepted
  logic        mon_prev_stall = 1'b0;
  logic [63:0] mon_prev_word = '0;

  aib_link_bringup_ctrl #(
    .NUM_CFG      (NUM_CFG),
    .RST_HOLD_CYC (RST_HOLD_CYC),
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .avmm_clk           (avmm_clk),
    .avmm_rst_n         (avmm_rst_n),
    .start              (start),
    .cfg_table          (cfg_table),
    .o_cfg_avmm_addr    (o_cfg_avmm_addr),
    .o_cfg_avmm_byte_en (o_cfg_avmm_byte_en),
    .o_cfg_avmm_write   (o_cfg_avmm_write),
    .o_cfg_avmm_wdata   (o_cfg_avmm_wdata),
    .i_cfg_avmm_waitreq (i_cfg_avmm_waitreq),
    .ns_adapter_rstn    (ns_adapter_rstn),
    .i_conf_done        (i_conf_done),
    .ns_mac_rdy         (ns_mac_rdy),
    .ms_tx_transfer_en  (ms_tx_transfer_en),
    .ms_rx_transfer_en  (ms_rx_transfer_en),
    .sl_tx_transfer_en  (sl_tx_transfer_en),
    .sl_rx_transfer_en  (sl_rx_transfer_en),
    .m_rx_align_done    (m_rx_align_done),
    .link_up            (link_up),
    .link_err           (link_err),
    .retry_cnt          (retry_cnt),
    .state_o            (state_o)
  );

  always #5 avmm_clk = ~avmm_clk;

  // Observed control bundle: {state, adapter_rstn, write, conf_done, mac_rdy, link_up, link_err}
  function automatic logic [8:0] ctl();
    return {state_o, ns_adapter_rstn, o_cfg_avmm_write, i_conf_done, ns_mac_rdy, link_up, link_err};
  endfunction

  // Required control bundle for each state, straight from the per-state output rules
  function automatic logic [8:0] spec_ctl(input logic [2:0] st);
    case (st)
      ST_IDLE:  return {ST_IDLE,  6'b000000};
      ST_RST:   return {ST_RST,   6'b000000};
      ST_CFG:   return {ST_CFG,   6'b110000};
      ST_CONF:  return {ST_CONF,  6'b101100};
      ST_WAIT:  return {ST_WAIT,  6'b101100};
      ST_UP:    return {ST_UP,    6'b101110};
      ST_ERROR: return {ST_ERROR, 6'b000001};
      default:  return 9'h1ff;
    endcase
  endfunction

  // AVMM monitor: records accepted writes and checks stall stability
  always @(negedge avmm_clk) begin
    if (!avmm_rst_n) begin
      mon_prev_stall = 1'b0;
    end else begin
      if (mon_prev_stall) begin
        checks++;
        if (o_cfg_avmm_write !== 1'b1 || {o_cfg_avmm_addr, o_cfg_avmm_wdata} !== mon_prev_word ||
            o_cfg_avmm_byte_en !== 4'hF) begin
          errors++;
          $display("FAIL avmm_hold: got write=%b word=%h be=%h required write=1 word=%h be=f",
                   o_cfg_avmm_write, {o_cfg_avmm_addr, o_cfg_avmm_wdata}, o_cfg_avmm_byte_en, mon_prev_word);
        end
      end
      if (o_cfg_avmm_write === 1'b1 && i_cfg_avmm_waitreq === 1'b0)
        acc_q.push_back({o_cfg_avmm_addr, o_cfg_avmm_wdata});
      mon_prev_stall = (o_cfg_avmm_write === 1'b1) && (i_cfg_avmm_waitreq === 1'b1);
      mon_prev_word  = {o_cfg_avmm_addr, o_cfg_avmm_wdata};
    end
  end

  task automatic tick();
    @(posedge avmm_clk);
    #1;
  endtask

  task automatic set_status(input logic v);
    ms_tx_transfer_en = v;
    ms_rx_transfer_en = v;
    sl_tx_transfer_en = v;
    sl_rx_transfer_en = v;
    m_rx_align_done   = v;
  endtask

  task automatic new_table();
    for (int i = 0; i < NUM_CFG; i++) begin
      tbl[i] = {$urandom, $urandom};
      cfg_table[64*i +: 64] = tbl[i];
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    i_cfg_avmm_waitreq = 1'b0;
    set_status(1'b0);
    avmm_rst_n = 1'b0;
    repeat (2) @(posedge avmm_clk);
    #1;
    avmm_rst_n = 1'b1;
    acc_q.delete();
  endtask

  // RST_HOLD_CYC cycles of adapter reset, starting one tick from now
  task automatic rst_phase(input string name, input logic [3:0] exp_retry);
    for (int k = 1; k <= RST_HOLD_CYC; k++) begin
      tick();
      checks++;
      if (ctl() !== spec_ctl(ST_RST) || retry_cnt !== exp_retry) begin
        errors++;
        $display("FAIL %s rst cycle %0d: got ctl=%b retry=%0d required ctl=%b retry=%0d",
                 name, k, ctl(), retry_cnt, spec_ctl(ST_RST), exp_retry);
      end
    end
  endtask

  // Write sequence; entry stall_entry is held off by waitreq for stall_len cycles.
  // Ends observing the CONF cycle.
  task automatic cfg_phase(input string name, input int stall_entry, input int stall_len);
    int idx;
    int left;
    idx  = 0;
    left = stall_len;
    tick();
    for (int n = 0; n < 64 && idx < NUM_CFG; n++) begin
      i_cfg_avmm_waitreq = (idx == stall_entry) && (left > 0);
      checks++;
      if (ctl() !== spec_ctl(ST_CFG) || o_cfg_avmm_byte_en !== 4'hF ||
          {o_cfg_avmm_addr, o_cfg_avmm_wdata} !== tbl[idx]) begin
        errors++;
        $display("FAIL %s entry %0d: got ctl=%b be=%h word=%h required ctl=%b be=f word=%h",
                 name, idx, ctl(), o_cfg_avmm_byte_en, {o_cfg_avmm_addr, o_cfg_avmm_wdata},
                 spec_ctl(ST_CFG), tbl[idx]);
      end
      if (i_cfg_avmm_waitreq) left--;
      else idx++;
      tick();
    end
    i_cfg_avmm_waitreq = 1'b0;
    checks++;
    if (ctl() !== spec_ctl(ST_CONF) || o_cfg_avmm_byte_en !== 4'h0) begin
      errors++;
      $display("FAIL %s conf: got ctl=%b be=%h required ctl=%b be=0",
               name, ctl(), o_cfg_avmm_byte_en, spec_ctl(ST_CONF));
    end
  endtask

  task automatic check_writes(input string name, input int n);
    checks++;
    if (acc_q.size() != n) begin
      errors++;
      $display("FAIL %s write count: got %0d required %0d", name, acc_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (acc_q[i] !== tbl[i]) begin
          errors++;
          $display("FAIL %s write %0d: got %h required %h", name, i, acc_q[i], tbl[i]);
        end
      end
    end
    acc_q.delete();
  endtask

  // From the CONF cycle: status rises d cycles later (or is already up); link_up 3 cycles after
  task automatic link_wait(input string name, input int d, input bit already_high);
    int up_k;
    up_k = already_high ? 2 : d + 3;
    if (!already_high && d == 0) set_status(1'b1);
    for (int k = 1; k <= up_k; k++) begin
      tick();
      if (!already_high && k == d) set_status(1'b1);
      checks++;
      if (ctl() !== spec_ctl((k >= up_k) ? ST_UP : ST_WAIT)) begin
        errors++;
        $display("FAIL %s wait cycle %0d: got ctl=%b required ctl=%b",
                 name, k, ctl(), spec_ctl((k >= up_k) ? ST_UP : ST_WAIT));
      end
    end
  endtask

  // From the CONF cycle with status low: TIMEOUT_CYC cycles in WAIT_LINK
  task automatic timeout_phase(input string name, input bit drop_start);
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      tick();
      checks++;
      if (ctl() !== spec_ctl(ST_WAIT)) begin
        errors++;
        $display("FAIL %s timeout cycle %0d: got ctl=%b required ctl=%b",
                 name, k, ctl(), spec_ctl(ST_WAIT));
      end
    end
    if (drop_start) start = 1'b0;
  endtask

  task automatic test_reset();
    avmm_rst_n = 1'b0;
    #1;
    checks++;
    if ({ctl(), o_cfg_avmm_addr, o_cfg_avmm_wdata, o_cfg_avmm_byte_en, retry_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values: got ctl=%b addr=%h wdata=%h be=%h retry=%0d required all zero",
               ctl(), o_cfg_avmm_addr, o_cfg_avmm_wdata, o_cfg_avmm_byte_en, retry_cnt);
    end
    do_reset();
    repeat (3) tick();
    checks++;
    if (ctl() !== spec_ctl(ST_IDLE) || retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL idle_hold: got ctl=%b retry=%0d required ctl=%b retry=0", ctl(), retry_cnt, spec_ctl(ST_IDLE));
    end
  endtask

  task automatic test_nominal();
    new_table();
    do_reset();
    start = 1'b1;
    rst_phase("nominal", 4'd0);
    cfg_phase("nominal", -1, 0);
    check_writes("nominal", NUM_CFG);
    link_wait("nominal", 20, 1'b0);
    checks++;
    if (retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL nominal retry: got %0d required 0", retry_cnt);
    end
  endtask

  task automatic test_waitreq_stall();
    for (int r = 0; r < 4; r++) begin
      int e;
      int len;
      e   = (r == 0) ? 2 : int'($urandom_range(0, NUM_CFG - 1));
      len = (r == 0) ? 5 : int'($urandom_range(1, 6));
      new_table();
      do_reset();
      start = 1'b1;
      rst_phase("stall", 4'd0);
      cfg_phase("stall", e, len);
      check_writes("stall", NUM_CFG);
      link_wait("stall", int'($urandom_range(1, 40)), 1'b0);
    end
  endtask

  task automatic test_timeout_retry();
    new_table();
    do_reset();
    start = 1'b1;
    rst_phase("timeout_a1", 4'd0);
    cfg_phase("timeout_a1", int'($urandom_range(0, NUM_CFG - 1)), int'($urandom_range(0, 3)));
    check_writes("timeout_a1", NUM_CFG);
    timeout_phase("timeout_a1", 1'b0);
    rst_phase("timeout_a2", 4'd1);
    cfg_phase("timeout_a2", -1, 0);
    check_writes("timeout_a2", NUM_CFG);
    link_wait("timeout_a2", int'($urandom_range(0, 60)), 1'b0);
    checks++;
    if (retry_cnt !== 4'd1) begin
      errors++;
      $display("FAIL timeout retry_cnt: got %0d required 1", retry_cnt);
    end
  endtask

  task automatic test_exhaustion();
    new_table();
    do_reset();
    start = 1'b1;
    for (int a = 0; a < MAX_RETRY; a++) begin
      rst_phase("exhaust", 4'(a));
      cfg_phase("exhaust", -1, 0);
      check_writes("exhaust", NUM_CFG);
      timeout_phase("exhaust", 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ctl() !== spec_ctl(ST_ERROR) || retry_cnt !== 4'(MAX_RETRY)) begin
        errors++;
        $display("FAIL exhaust error %0d: got ctl=%b retry=%0d required ctl=%b retry=%0d",
                 k, ctl(), retry_cnt, spec_ctl(ST_ERROR), MAX_RETRY);
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (ctl() !== spec_ctl(ST_IDLE)) begin
      errors++;
      $display("FAIL exhaust idle: got ctl=%b required ctl=%b", ctl(), spec_ctl(ST_IDLE));
    end
    start = 1'b1;
    tick();
    checks++;
    if (ctl() !== spec_ctl(ST_RST) || retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL exhaust restart: got ctl=%b retry=%0d required ctl=%b retry=0",
               ctl(), retry_cnt, spec_ctl(ST_RST));
    end
  endtask

  task automatic test_link_loss();
    new_table();
    do_reset();
    start = 1'b1;
    rst_phase("loss", 4'd0);
    cfg_phase("loss", -1, 0);
    check_writes("loss", NUM_CFG);
    link_wait("loss", int'($urandom_range(1, 30)), 1'b0);
    repeat ($urandom_range(1, 5)) tick();
    sl_rx_transfer_en = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      sl_rx_transfer_en = 1'b1;
      checks++;
      if (ctl() !== spec_ctl(ST_UP)) begin
        errors++;
        $display("FAIL loss latency %0d: got ctl=%b required ctl=%b", k, ctl(), spec_ctl(ST_UP));
      end
    end
    rst_phase("loss_retry", 4'd1);
    cfg_phase("loss_retry", -1, 0);
    check_writes("loss_retry", NUM_CFG);
    link_wait("loss_retry", 0, 1'b1);
  endtask

  task automatic test_abort();
    int e;
    int len;
    // abort while a write is stalled
    e   = int'($urandom_range(0, NUM_CFG - 1));
    len = int'($urandom_range(2, 6));
    new_table();
    do_reset();
    start = 1'b1;
    rst_phase("abort_stall", 4'd0);
    tick();
    for (int i = 0; i <= e + len; i++) begin
      int cur;
      cur = (i < e) ? i : e;
      i_cfg_avmm_waitreq = (i >= e) && (i < e + len);
      if (i == e) start = 1'b0;
      checks++;
      if (ctl() !== spec_ctl(ST_CFG) || {o_cfg_avmm_addr, o_cfg_avmm_wdata} !== tbl[cur]) begin
        errors++;
        $display("FAIL abort_stall cycle %0d: got ctl=%b word=%h required ctl=%b word=%h",
                 i, ctl(), {o_cfg_avmm_addr, o_cfg_avmm_wdata}, spec_ctl(ST_CFG), tbl[cur]);
      end
      tick();
    end
    checks++;
    if (ctl() !== spec_ctl(ST_IDLE) || retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL abort_stall idle: got ctl=%b retry=%0d required ctl=%b retry=0",
               ctl(), retry_cnt, spec_ctl(ST_IDLE));
    end
    check_writes("abort_stall", e + 1);
    // abort in the same cycle as the final timeout (would otherwise reach ERROR)
    do_reset();
    start = 1'b1;
    for (int a = 0; a < MAX_RETRY; a++) begin
      rst_phase("abort_timeout", 4'(a));
      cfg_phase("abort_timeout", -1, 0);
      check_writes("abort_timeout", NUM_CFG);
      timeout_phase("abort_timeout", a == MAX_RETRY - 1);
    end
    tick();
    checks++;
    if (ctl() !== spec_ctl(ST_IDLE)) begin
      errors++;
      $display("FAIL abort_timeout idle: got ctl=%b required ctl=%b", ctl(), spec_ctl(ST_IDLE));
    end
  endtask

  task automatic test_async_reset();
    new_table();
    do_reset();
    start = 1'b1;
    rst_phase("async_rst", 4'd0);
    tick();
    i_cfg_avmm_waitreq = 1'b1;
    #2;
    avmm_rst_n = 1'b0;
    #1;
    checks++;
    if (o_cfg_avmm_write !== 1'b0 || ctl() !== spec_ctl(ST_IDLE)) begin
      errors++;
      $display("FAIL async_rst: got write=%b ctl=%b required write=0 ctl=%b",
               o_cfg_avmm_write, ctl(), spec_ctl(ST_IDLE));
    end
    do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_waitreq_stall();
    test_timeout_retry();
    test_exhaustion();
    test_link_loss();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
